// File: rtl/ps2_move_decoder_pkg.sv
// Shared move encoding, PS/2 scan-code constants and the make-code map
// used by the PS/2 keyboard move decoder.
package ps2_move_decoder_pkg;

  typedef enum logic [2:0] {
    MV_NONE  = 3'd0,
    MV_UP    = 3'd1,
    MV_DOWN  = 3'd2,
    MV_LEFT  = 3'd3,
    MV_RIGHT = 3'd4,
    MV_PLAY  = 3'd5,
    MV_RESET = 3'd6
  } move_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_R     = 8'h2D;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

  // Keypad arrows arrive without the E0 prefix and fall through to MV_NONE.
  function automatic move_e map_make(input logic ext, input logic [7:0] code);
    move_e mv;
    mv = MV_NONE;
    if (ext) begin
      case (code)
        KEY_UP:    mv = MV_UP;
        KEY_DOWN:  mv = MV_DOWN;
        KEY_LEFT:  mv = MV_LEFT;
        KEY_RIGHT: mv = MV_RIGHT;
        default:   mv = MV_NONE;
      endcase
    end else begin
      case (code)
        KEY_W:     mv = MV_UP;
        KEY_S:     mv = MV_DOWN;
        KEY_A:     mv = MV_LEFT;
        KEY_D:     mv = MV_RIGHT;
        KEY_SPACE: mv = MV_PLAY;
        KEY_R:     mv = MV_RESET;
        default:   mv = MV_NONE;
      endcase
    end
    return mv;
  endfunction

endpackage

// File: rtl/ps2_move_decoder_rx.sv
// PS/2 frame receiver: pin synchronizers, ps2_clk glitch filter, frame FSM
// with parity/start/stop checking and a mid-frame inactivity timeout.
module ps2_move_decoder_rx
  import ps2_move_decoder_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_byte_o,
  output logic       byte_valid_o,
  output logic       err_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_q;
  logic [CW-1:0] filt_cnt_q;
  logic          strobe_q, data_smp_q;
  logic          filt_flip;

  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          byte_valid_q, byte_valid_d;
  logic          err_q, err_d;

  assign filt_flip = (clk_sync_q[1] != filt_q) && (filt_cnt_q == CW'(FILTER_LEN - 1));

  // Idle bus level is high, so synchronizers and filter reset to 1 to avoid a
  // false falling edge straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      strobe_q    <= 1'b0;
      data_smp_q  <= 1'b1;
    end else begin
      // NOTE: all sequential state uses non-blocking assignment so every
      // register samples the pre-edge value of its neighbours.
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      if (clk_sync_q[1] == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_flip) begin
        filt_q     <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
      strobe_q   <= filt_flip && filt_q;
      data_smp_q <= data_sync_q[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_ok_q     <= 1'b0;
      timer_q      <= '0;
      byte_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_ok_q     <= par_ok_d;
      timer_q      <= timer_d;
      byte_valid_q <= byte_valid_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_ok_d     = par_ok_q;
    timer_d      = timer_q;
    byte_valid_d = 1'b0;
    err_d        = 1'b0;
    if (strobe_q) begin
      timer_d = '0;
      case (state_q)
        RX_IDLE: begin
          if (!data_smp_q) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        RX_DATA: begin
          shift_d   = {data_smp_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_ok_d = ^{data_smp_q, shift_q};
          state_d  = RX_STOP;
        end
        RX_STOP: begin
          if (data_smp_q && par_ok_q) byte_valid_d = 1'b1;
          else                        err_d        = 1'b1;
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE) begin
      // A strobe in the expiry cycle takes the branch above, so it wins.
      if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = RX_IDLE;
        timer_d = '0;
        err_d   = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  assign rx_byte_o    = shift_q;
  assign byte_valid_o = byte_valid_q;
  assign err_o        = err_q;

endmodule

// File: rtl/ps2_move_decoder.sv
// Turns PS/2 make codes into single-cycle game move pulses; tracks the E0/F0
// prefixes and exposes the last good byte for debug.
module ps2_move_decoder
  import ps2_move_decoder_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] move,
  output logic       frame_err,
  output logic [7:0] scan_code
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  move_e      move_q, move_d;
  logic       err_q;
  logic [7:0] scan_q, scan_d;
  logic       ext_q, ext_d, brk_q, brk_d;

  ps2_move_decoder_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .rx_byte_o   (rx_byte),
    .byte_valid_o(rx_valid),
    .err_o       (rx_err)
  );

  always_comb begin
    move_d = MV_NONE;
    scan_d = scan_q;
    ext_d  = ext_q;
    brk_d  = brk_q;
    if (rx_valid) begin
      scan_d = rx_byte;
      if (rx_byte == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        move_d = map_make(ext_q, rx_byte);
        ext_d  = 1'b0;
      end
    end
  end

  // rx_valid and rx_err never coincide, so move and frame_err stay exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      move_q <= MV_NONE;
      err_q  <= 1'b0;
      scan_q <= 8'h00;
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      move_q <= move_d;
      err_q  <= rx_err;
      scan_q <= scan_d;
      ext_q  <= ext_d;
      brk_q  <= brk_d;
    end
  end

  assign move      = move_q;
  assign frame_err = err_q;
  assign scan_code = scan_q;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Randomized and directed PS/2 frame stimulus scored against a key-sequence
// model of prefix handling and the make-code map.
module tb_ps2_move_decoder;
  import ps2_move_decoder_pkg::*;

  localparam int FILT    = 8;
  localparam int TMO     = 200;
  localparam int HALF    = 20;
  localparam int GAP     = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [2:0] move;
  logic       frame_err;
  logic [7:0] scan_code;

  ps2_move_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .move     (move),
    .frame_err(frame_err),
    .scan_code(scan_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: prefix flags, last good byte, expected moves and error count.
  int     make_map[int];
  int     exp_q[$];
  bit     m_ext, m_brk;
  int     m_scan;
  int     exp_err;
  int     err_seen;
  bit     mon_en;
  int     prev_move;
  bit     prev_err;

  function automatic void model_byte(input int b);
    int key;
    m_scan = b;
    if (b == 'hE0) m_ext = 1'b1;
    else if (b == 'hF0) m_brk = 1'b1;
    else if (m_brk) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else begin
      key = (m_ext ? 256 : 0) + b;
      if (make_map.exists(key)) exp_q.push_back(make_map[key]);
      m_ext = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (move != MV_NONE) begin
        if (exp_q.size() == 0) check("unexpected_move", move, MV_NONE);
        else                   check("move", move, exp_q.pop_front());
        if (prev_move != MV_NONE) check("move_width", prev_move, MV_NONE);
        if (frame_err) check("err_with_move", frame_err, 0);
      end
      if (frame_err) begin
        err_seen++;
        if (prev_err) check("err_width", prev_err, 0);
      end
      prev_move = move;
      prev_err  = frame_err;
    end
  end

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic settle_check(input string tag);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_scan"}, scan_code, m_scan);
    check({tag, "_errs"}, err_seen, exp_err);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input string tag);
    if (bad_par) exp_err++;
    else         model_byte(b);
    send_bits(b, bad_par, 11);
    settle_check(tag);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pool [12];
    logic [7:0] b;
    int         pick;
    pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23,
             8'h29, 8'h2D, 8'h75, 8'h72, 8'h6B, 8'h74};
    make_map[256 + 'h75] = MV_UP;   make_map['h1D] = MV_UP;
    make_map[256 + 'h72] = MV_DOWN; make_map['h1B] = MV_DOWN;
    make_map[256 + 'h6B] = MV_LEFT; make_map['h1C] = MV_LEFT;
    make_map[256 + 'h74] = MV_RIGHT; make_map['h23] = MV_RIGHT;
    make_map['h29] = MV_PLAY;
    make_map['h2D] = MV_RESET;

    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_move", move, MV_NONE);
    check("rst_err", frame_err, 0);
    check("rst_scan", scan_code, 8'h00);
    prev_move = MV_NONE;
    prev_err  = 1'b0;
    mon_en    = 1'b1;

    send_byte(8'h1D, 0, "t1_w");

    send_byte(8'hE0, 0, "t2_e0");
    send_byte(8'h6B, 0, "t2_left");
    send_byte(8'h6B, 0, "t2_keypad");

    send_byte(8'hF0, 0, "t3_f0");
    send_byte(8'h1D, 0, "t3_brk_w");
    send_byte(8'hE0, 0, "t3_e0");
    send_byte(8'hF0, 0, "t3_f0b");
    send_byte(8'h75, 0, "t3_brk_up");
    send_byte(8'h1D, 0, "t3_w");

    send_byte(8'h29, 1, "t4_badpar");
    send_byte(8'h2D, 0, "t4_r");

    send_bits(8'h5A, 0, 5);
    repeat (TMO + 50) @(negedge clk);
    exp_err++;
    settle_check("t5_timeout");
    send_byte(8'h23, 0, "t5_d");

    send_byte(8'hE0, 0, "t6_e0");
    send_bits(8'h75, 0, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_scan = 0;
    repeat (TMO + 50) @(negedge clk);
    check("t6_rst_move", move, MV_NONE);
    settle_check("t6_rst");
    send_byte(8'h75, 0, "t6_keypad");
    send_byte(8'h29, 0, "t6_space");
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (GAP) @(negedge clk);
    settle_check("t6_glitch");

    for (int i = 0; i < 25; i++) begin
      pick = $urandom_range(0, 13);
      b    = (pick < 12) ? pool[pick] : 8'($urandom);
      send_byte(b, $urandom_range(0, 7) == 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
